// File: rtl/dpll_fll_ctrl.sv
`timescale 1ns / 1ps
// Frequency-locked-loop trim controller for the DPLL DCO, clocked by the DCO feedback clock.
// Optional fast acquisition (step of 4 while unlocked and far off) under DPLL_FLL_FAST_ACQ_EN.
module dpll_fll_ctrl #(
    parameter int unsigned TRIM_W   = 26,
    parameter int unsigned DIV_W    = 5,
    parameter int unsigned WIN_LOG2 = 0,
    parameter int unsigned DEADBAND = 1,
    parameter int unsigned LOCK_CNT = 8
) (
    input  logic                    clock,
    input  logic                    resetb,
    input  logic                    enable,
    input  logic                    osc,
    input  logic [DIV_W-1:0]        div,
    input  logic                    dco,
    input  logic [TRIM_W-1:0]       ext_trim,
    output logic [TRIM_W-1:0]       trim,
    output logic                    locked,
    output logic [DIV_W+WIN_LOG2:0] count_out
);
    localparam int unsigned CW = DIV_W + WIN_LOG2 + 1;
    localparam int unsigned LW = $clog2(TRIM_W + 1);
    localparam int unsigned BW = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
    localparam int unsigned IW = (LOCK_CNT > 0) ? $clog2(LOCK_CNT + 1) : 1;
    localparam int unsigned XW = LW + 3;

    function automatic logic [TRIM_W-1:0] therm(input logic [LW-1:0] lvl);
        logic [TRIM_W-1:0] t;
        for (int i = 0; i < int'(TRIM_W); i++) begin
            t[i] = (i < int'(lvl));
        end
        return t;
    endfunction

    localparam logic [LW-1:0]     LVL_RST  = LW'(TRIM_W / 2);
    localparam logic [TRIM_W-1:0] TRIM_RST = therm(LVL_RST);
    localparam logic [BW-1:0]     WIN_LAST = BW'((1 << WIN_LOG2) - 1);
    localparam logic signed [CW:0] DB      = (CW + 1)'(DEADBAND);
    localparam logic [IW-1:0]     IB_FULL  = IW'(LOCK_CNT);

    logic [2:0]        sync_q;
    logic [BW-1:0]     bnd_q, bnd_d;
    logic [CW-1:0]     m_q, m_d;
    logic              started_q, started_d;
    logic [CW-1:0]     count_q, count_d;
    logic [LW-1:0]     level_q, level_d;
    logic [TRIM_W-1:0] trim_q, trim_d;
    logic [IW-1:0]     ib_q, ib_d;
    logic              locked_q, locked_d;

    logic              pulse, closure, run, eval;
    logic [DIV_W-1:0]  div_eff;
    logic [CW-1:0]     target;
    logic signed [CW:0] err;
    logic              up, dn;
    logic [2:0]        step;
    logic [XW-1:0]     lvl_ext, step_ext, lvl_sum, lvl_up, lvl_dn;

    assign pulse   = sync_q[1] & ~sync_q[2];
    assign closure = pulse && (bnd_q == WIN_LAST);
    assign run     = enable && !dco;
    assign eval    = run && closure && started_q;

    assign div_eff = (div == '0) ? DIV_W'(1) : div;
    assign target  = CW'(div_eff) << WIN_LOG2;
    assign err     = $signed({1'b0, m_q}) - $signed({1'b0, target});
    assign up      = err > DB;
    assign dn      = err < -DB;

`ifdef DPLL_FLL_FAST_ACQ_EN
    localparam logic signed [CW:0] FAST_TH = (CW + 1)'(4 * (DEADBAND + 1));
    assign step = (!locked_q && (err > FAST_TH || err < -FAST_TH)) ? 3'd4 : 3'd1;
`else
    assign step = 3'd1;
`endif

    assign lvl_ext  = XW'(level_q);
    assign step_ext = XW'(step);
    assign lvl_sum  = lvl_ext + step_ext;
    assign lvl_up   = (lvl_sum > XW'(TRIM_W)) ? XW'(TRIM_W) : lvl_sum;
    assign lvl_dn   = (lvl_ext < step_ext) ? '0 : lvl_ext - step_ext;

    always_comb begin
        bnd_d     = bnd_q;
        m_d       = m_q;
        started_d = started_q;
        count_d   = count_q;
        level_d   = level_q;
        ib_d      = ib_q;
        if (!run) begin
            // Disabled or bypassed: restart measurement so the next closure only opens a window.
            bnd_d     = '0;
            m_d       = '0;
            started_d = 1'b0;
            ib_d      = '0;
            if (dco) begin
                level_d = LVL_RST;
            end
        end else begin
            if (pulse) begin
                bnd_d = closure ? '0 : bnd_q + 1'b1;
            end
            if (closure) begin
                m_d       = CW'(1);
                started_d = 1'b1;
            end else if (m_q != '1) begin
                m_d = m_q + 1'b1;
            end
            if (eval) begin
                count_d = m_q;
                if (up) begin
                    level_d = LW'(lvl_up);
                end else if (dn) begin
                    level_d = LW'(lvl_dn);
                end
                if (up || dn) begin
                    ib_d = '0;
                end else if (ib_q != IB_FULL) begin
                    ib_d = ib_q + 1'b1;
                end
            end
        end
        trim_d   = dco ? ext_trim : therm(level_q);
        locked_d = (ib_d == IB_FULL);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync_q    <= '0;
            bnd_q     <= '0;
            m_q       <= '0;
            started_q <= 1'b0;
            count_q   <= '0;
            level_q   <= LVL_RST;
            trim_q    <= TRIM_RST;
            ib_q      <= '0;
            locked_q  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[1:0], osc};
            bnd_q     <= bnd_d;
            m_q       <= m_d;
            started_q <= started_d;
            count_q   <= count_d;
            level_q   <= level_d;
            trim_q    <= trim_d;
            ib_q      <= ib_d;
            locked_q  <= locked_d;
        end
    end

    assign trim      = trim_q;
    assign locked    = locked_q;
    assign count_out = count_q;

endmodule

// File: tb/tb_dpll_fll_ctrl.sv
`timescale 1ns / 1ps
// Bench for dpll_fll_ctrl: per-edge behavioural model of the loop rules plus directed literal checks.
module tb_dpll_fll_ctrl;
    localparam int TRIM_W   = 26;
    localparam int CW       = 6;
    localparam int LOCK_CNT = 8;
    localparam int DEADBAND = 1;
    localparam int MID      = TRIM_W / 2;

    logic              clock = 1'b0;
    logic              resetb;
    logic              enable;
    logic              osc = 1'b0;
    logic              dco;
    logic [4:0]        div;
    logic [TRIM_W-1:0] ext_trim;
    logic [TRIM_W-1:0] trim;
    logic              locked;
    logic [CW-1:0]     count_out;

    int vectors     = 0;
    int miscompares = 0;
    int hi_cyc      = 4;
    int lo_cyc      = 4;
    int osc_cnt     = 0;
    bit chk_en      = 1'b0;

    dpll_fll_ctrl dut (
        .clock     (clock),
        .resetb    (resetb),
        .enable    (enable),
        .osc       (osc),
        .div       (div),
        .dco       (dco),
        .ext_trim  (ext_trim),
        .trim      (trim),
        .locked    (locked),
        .count_out (count_out)
    );

    always #1.25 clock = ~clock;

    // Reference clock derived from clock cycles so the osc period in clocks is exact.
    always @(negedge clock) begin
        osc_cnt = osc_cnt + 1;
        if (osc && osc_cnt >= hi_cyc) begin
            osc     = 1'b0;
            osc_cnt = 0;
        end else if (!osc && osc_cnt >= lo_cyc) begin
            osc     = 1'b1;
            osc_cnt = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [TRIM_W-1:0] therm(input int lvl);
        return TRIM_W'((64'd1 << lvl) - 64'd1);
    endfunction

    // Model state: level, last count, in-band run length, lock and trim as seen after each edge.
    int                n_edge = 0;
    int                close_at = -1;
    int                last_close = 0;
    int                m_level = MID;
    int                m_count = 0;
    int                m_ib = 0;
    bit                m_lock = 1'b0;
    bit                osc_seen = 1'b0;
    bit                armed = 1'b0;
    bit                closing;
    logic [TRIM_W-1:0] m_trim = 26'h1FFF;
    logic [TRIM_W-1:0] nxt_trim;

    task automatic evaluate(input int m_raw);
        int m, t, e, step;
        m = (m_raw > 63) ? 63 : m_raw;
        t = (div == 5'd0) ? 1 : int'(div);
        e = m - t;
        step = 1;
`ifdef DPLL_FLL_FAST_ACQ_EN
        if (!m_lock && (e > 4 * (DEADBAND + 1) || e < -4 * (DEADBAND + 1))) step = 4;
`endif
        m_count = m;
        if (e > DEADBAND) begin
            m_level = (m_level + step > TRIM_W) ? TRIM_W : m_level + step;
            m_ib    = 0;
        end else if (e < -DEADBAND) begin
            m_level = (m_level - step < 0) ? 0 : m_level - step;
            m_ib    = 0;
        end else if (m_ib < LOCK_CNT) begin
            m_ib = m_ib + 1;
        end
    endtask

    always @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            n_edge = 0; close_at = -1; last_close = 0; osc_seen = 1'b0; armed = 1'b0;
            m_level = MID; m_count = 0; m_ib = 0; m_lock = 1'b0; m_trim = therm(MID);
        end else begin
            n_edge   = n_edge + 1;
            nxt_trim = dco ? ext_trim : therm(m_level);
            closing  = (close_at == n_edge);
            // A rising osc first seen at edge k is acted on two edges later.
            if (osc && !osc_seen) close_at = n_edge + 2;
            osc_seen = osc;
            if (dco) begin
                armed = 1'b0; m_ib = 0; m_level = MID;
            end else if (!enable) begin
                armed = 1'b0; m_ib = 0;
            end else if (closing) begin
                if (armed) evaluate(n_edge - last_close);
                armed      = 1'b1;
                last_close = n_edge;
            end
            m_lock = (m_ib == LOCK_CNT);
            m_trim = nxt_trim;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("trim", 32'(trim), 32'(m_trim));
            chk("locked", 32'(locked), 32'(m_lock));
            chk("count_out", 32'(count_out), 32'(m_count));
        end
    end

    initial begin
        resetb = 1'b0; enable = 1'b1; dco = 1'b0; div = 5'd8; ext_trim = '0;
        repeat (3) @(negedge clock);
        chk("rst_trim", 32'(trim), 32'h1FFF);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_count", 32'(count_out), 32'd0);
        chk_en = 1'b1;
        resetb = 1'b1;

        // Ratio 8, div 8: stays at mid trim and locks.
        repeat (120) @(negedge clock);
        chk("lock_trim", 32'(trim), 32'h1FFF);
        chk("lock_count", 32'(count_out), 32'd8);
        chk("lock_locked", 32'(locked), 32'd1);

        // Ratio 11: lock breaks, level climbs.
        hi_cyc = 6; lo_cyc = 5;
        repeat (110) @(negedge clock);
        chk("brk_locked", 32'(locked), 32'd0);
        chk("brk_count", 32'(count_out), 32'd11);
        chk("brk_level_ge20", 32'(trim[19]), 32'd1);

        // Asynchronous reset mid-window, no clock edge in between.
        @(posedge clock);
        #0.4 resetb = 1'b0;
        #0.2;
        chk("arst_trim", 32'(trim), 32'h1FFF);
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_count", 32'(count_out), 32'd0);
        @(negedge clock);
        resetb = 1'b1;

        // Ratio 8, div 10: level walks down to 0 and holds.
        hi_cyc = 4; lo_cyc = 4; div = 5'd10;
        repeat (180) @(negedge clock);
        chk("under_trim", 32'(trim), 32'd0);
        chk("under_locked", 32'(locked), 32'd0);
        chk("under_count", 32'(count_out), 32'd8);

        // Ratio 10, div 8: level walks up to full scale.
        hi_cyc = 5; lo_cyc = 5; div = 5'd8;
        repeat (320) @(negedge clock);
        chk("over_trim", 32'(trim), 32'h3FFFFFF);
        chk("over_locked", 32'(locked), 32'd0);
        chk("over_count", 32'(count_out), 32'd10);

        // Bypass and release.
        dco = 1'b1; ext_trim = 26'h155;
        @(negedge clock);
        chk("byp_trim", 32'(trim), 32'h155);
        chk("byp_locked", 32'(locked), 32'd0);
        ext_trim = 26'h2AA;
        repeat (5) @(negedge clock);
        chk("byp_trim2", 32'(trim), 32'h2AA);
        dco = 1'b0;
        @(negedge clock);
        chk("rel_trim", 32'(trim), 32'h1FFF);
        repeat (9) @(negedge clock);
        chk("rel_noeval", 32'(trim), 32'h1FFF);

        // Disable holds trim; then div=0 acts as 1.
        repeat (30) @(negedge clock);
        enable = 1'b0;
        repeat (40) @(negedge clock);
        chk("dis_locked", 32'(locked), 32'd0);
        enable = 1'b1; div = 5'd0;
        repeat (80) @(negedge clock);
        chk("div0_count", 32'(count_out), 32'd10);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
